// File: rtl/fragment_hazard_scheduler.sv
// Issue gate that holds back fragments whose framebuffer index is still in flight.
// Optional stall counter is enabled by defining FRAGMENT_HAZARD_STALL_COUNTER_EN.
module fragment_hazard_scheduler #(
    parameter int FRAMEBUFFER_INDEX_WIDTH = 14,
    parameter int PAYLOAD_WIDTH           = 128,
    parameter int IN_FLIGHT_DEPTH         = 8
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 s_frag_tvalid,
    output logic                                 s_frag_tready,
    input  logic                                 s_frag_tlast,
    input  logic                                 s_frag_tkeep,
    input  logic [FRAMEBUFFER_INDEX_WIDTH-1:0]   s_frag_tindex,
    input  logic [PAYLOAD_WIDTH-1:0]             s_frag_tpayload,
    output logic                                 m_frag_tvalid,
    input  logic                                 m_frag_tready,
    output logic                                 m_frag_tlast,
    output logic                                 m_frag_tkeep,
    output logic [FRAMEBUFFER_INDEX_WIDTH-1:0]   m_frag_tindex,
    output logic [PAYLOAD_WIDTH-1:0]             m_frag_tpayload,
    input  logic                                 fragmentProcessed,
    input  logic                                 fragmentProcessedCe,
    input  logic                                 flush,
    output logic                                 flushDone,
    output logic [$clog2(IN_FLIGHT_DEPTH):0]     inFlight,
    output logic                                 retireError,
    output logic [1:0]                           fsm_state
`ifdef FRAGMENT_HAZARD_STALL_COUNTER_EN
    ,
    output logic [31:0]                          stallCycles
`endif
);

    localparam int PW = $clog2(IN_FLIGHT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IN_FLIGHT_DEPTH);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] DRAIN    = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    logic [1:0]                         state;
    logic [IN_FLIGHT_DEPTH-1:0]         sb_valid;
    logic [IN_FLIGHT_DEPTH-1:0]         sb_keep;
    logic [FRAMEBUFFER_INDEX_WIDTH-1:0] sb_index [IN_FLIGHT_DEPTH];
    logic [PW-1:0]                      wr_ptr;
    logic [PW-1:0]                      rd_ptr;
    logic [CW-1:0]                      in_flight;
    logic                               hazard;
    logic                               hit;
    logic                               accept;
    logic                               retire_req;
    logic                               do_retire;

    // Hazard looks only at registered entries, so a same-cycle retire still blocks.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < IN_FLIGHT_DEPTH; i++) begin
            if (sb_valid[i] && sb_keep[i] && (sb_index[i] == s_frag_tindex)) begin
                hit = 1'b1;
            end
        end
        hazard = hit & s_frag_tkeep;
    end

    // Both sides: a transfer happens on a cycle where valid and ready are high at the
    // clock edge; ready never depends on valid, and valid/data hold until transferred.
    assign s_frag_tready = (state == RUN) & ~flush & ~hazard & (in_flight < DEPTH_C)
                         & (~m_frag_tvalid | m_frag_tready);
    assign accept     = s_frag_tvalid & s_frag_tready;
    assign retire_req = fragmentProcessed & fragmentProcessedCe;
    assign do_retire  = retire_req & (in_flight != '0);

    assign inFlight  = in_flight;
    assign flushDone = (state == DONE);
    assign fsm_state = state;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sb_valid <= '0;
            sb_keep  <= '0;
            for (int i = 0; i < IN_FLIGHT_DEPTH; i++) begin
                sb_index[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_flight   <= '0;
            retireError <= 1'b0;
        end else begin
            if (do_retire) begin
                sb_valid[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (accept) begin
                sb_valid[wr_ptr] <= 1'b1;
                sb_keep[wr_ptr]  <= s_frag_tkeep;
                sb_index[wr_ptr] <= s_frag_tindex;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            case ({accept, do_retire})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase
            if (retire_req && (in_flight == '0)) begin
                retireError <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_frag_tvalid   <= 1'b0;
            m_frag_tlast    <= 1'b0;
            m_frag_tkeep    <= 1'b0;
            m_frag_tindex   <= '0;
            m_frag_tpayload <= '0;
        end else if (accept) begin
            m_frag_tvalid   <= 1'b1;
            m_frag_tlast    <= s_frag_tlast;
            m_frag_tkeep    <= s_frag_tkeep;
            m_frag_tindex   <= s_frag_tindex;
            m_frag_tpayload <= s_frag_tpayload;
        end else if (m_frag_tready) begin
            m_frag_tvalid   <= 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (flush) state <= DRAIN;
                DRAIN:    if ((in_flight == '0) && !m_frag_tvalid) state <= DONE;
                DONE:     state <= WAIT_REL;
                WAIT_REL: if (!flush) state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

`ifdef FRAGMENT_HAZARD_STALL_COUNTER_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stallCycles <= '0;
        end else if (state == DONE) begin
            stallCycles <= '0;
        end else if (s_frag_tvalid && hazard && (stallCycles != 32'hFFFF_FFFF)) begin
            stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fragment_hazard_scheduler.sv
// Bench for fragment_hazard_scheduler: directed scenarios plus random traffic,
// all checked against a queue-based model of the in-flight fragments.
module tb_fragment_hazard_scheduler;

    localparam int IW = 14;
    localparam int PW = 128;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    localparam int M_RUN  = 0;
    localparam int M_DRN  = 1;
    localparam int M_DONE = 2;
    localparam int M_WAIT = 3;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_frag_tvalid, s_frag_tready, s_frag_tlast, s_frag_tkeep;
    logic [IW-1:0] s_frag_tindex;
    logic [PW-1:0] s_frag_tpayload;
    logic          m_frag_tvalid, m_frag_tready, m_frag_tlast, m_frag_tkeep;
    logic [IW-1:0] m_frag_tindex;
    logic [PW-1:0] m_frag_tpayload;
    logic          fragmentProcessed, fragmentProcessedCe;
    logic          flush, flushDone, retireError;
    logic [CW-1:0] inFlight;
    logic [1:0]    fsm_state;
`ifdef FRAGMENT_HAZARD_STALL_COUNTER_EN
    logic [31:0]   stallCycles;
`endif

    always #5 aclk = ~aclk;

    fragment_hazard_scheduler #(
        .FRAMEBUFFER_INDEX_WIDTH(IW), .PAYLOAD_WIDTH(PW), .IN_FLIGHT_DEPTH(D)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_frag_tvalid(s_frag_tvalid), .s_frag_tready(s_frag_tready),
        .s_frag_tlast(s_frag_tlast), .s_frag_tkeep(s_frag_tkeep),
        .s_frag_tindex(s_frag_tindex), .s_frag_tpayload(s_frag_tpayload),
        .m_frag_tvalid(m_frag_tvalid), .m_frag_tready(m_frag_tready),
        .m_frag_tlast(m_frag_tlast), .m_frag_tkeep(m_frag_tkeep),
        .m_frag_tindex(m_frag_tindex), .m_frag_tpayload(m_frag_tpayload),
        .fragmentProcessed(fragmentProcessed), .fragmentProcessedCe(fragmentProcessedCe),
        .flush(flush), .flushDone(flushDone), .inFlight(inFlight),
        .retireError(retireError), .fsm_state(fsm_state)
`ifdef FRAGMENT_HAZARD_STALL_COUNTER_EN
        , .stallCycles(stallCycles)
`endif
    );

    // Scoreboard: fragments issued but not yet retired, oldest first, as {index, keep}.
    logic [IW:0]   exp_q[$];
    int            m_st;
    logic          mv, mkeep, mlast, merr;
    logic [IW-1:0] midx;
    logic [PW-1:0] mpay;
    logic [31:0]   mstall;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            peak;
    int            pulses;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit model_hazard(input logic keep, input logic [IW-1:0] idx);
        if (!keep) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i][0] && exp_q[i][IW:1] == idx) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_st = M_RUN; mv = 0; mkeep = 0; mlast = 0; midx = '0; mpay = '0;
        merr = 0; mstall = '0;
    endtask

    // One clock: check ready against the model, advance the model over the edge,
    // then check every registered output.
    task automatic step();
        bit hz, rdy, acc, ret;
        #1;
        hz  = model_hazard(s_frag_tkeep, s_frag_tindex);
        rdy = (m_st == M_RUN) && !flush && !hz && (exp_q.size() < D) && (!mv || m_frag_tready);
        check_val("s_frag_tready", s_frag_tready, rdy);
        acc = s_frag_tvalid && rdy;
        ret = fragmentProcessed && fragmentProcessedCe;
        @(posedge aclk);
        if (m_st == M_DONE) mstall = '0;
        else if (s_frag_tvalid && hz && mstall != 32'hFFFF_FFFF) mstall++;
        case (m_st)
            M_RUN:   if (flush) m_st = M_DRN;
            M_DRN:   if (exp_q.size() == 0 && !mv) m_st = M_DONE;
            M_DONE:  m_st = M_WAIT;
            default: if (!flush) m_st = M_RUN;
        endcase
        if (ret) begin
            if (exp_q.size() == 0) merr = 1;
            else void'(exp_q.pop_front());
        end
        if (acc) begin
            exp_q.push_back({s_frag_tindex, s_frag_tkeep});
            mv = 1; mkeep = s_frag_tkeep; mlast = s_frag_tlast; midx = s_frag_tindex;
            mpay = s_frag_tpayload;
        end else if (m_frag_tready) begin
            mv = 0;
        end
        #1;
        check_val("m_frag_tvalid", m_frag_tvalid, mv);
        check_val("inFlight", inFlight, exp_q.size());
        check_val("retireError", retireError, merr);
        check_val("flushDone", flushDone, m_st == M_DONE);
        if (mv) begin
            check_val("m_frag_tindex", m_frag_tindex, midx);
            check_val("m_frag_tkeep", m_frag_tkeep, mkeep);
            check_val("m_frag_tlast", m_frag_tlast, mlast);
            check_val("m_frag_tpayload", m_frag_tpayload, mpay);
        end
`ifdef FRAGMENT_HAZARD_STALL_COUNTER_EN
        check_val("stallCycles", stallCycles, mstall);
`endif
        if (int'(inFlight) > peak) peak = int'(inFlight);
        if (flushDone) pulses++;
    endtask

    task automatic drive(input bit v, input bit k, input logic [IW-1:0] idx, input bit r);
        s_frag_tvalid       = v;
        s_frag_tkeep        = k;
        s_frag_tindex       = idx;
        s_frag_tlast        = 1'($urandom_range(0, 1));
        s_frag_tpayload     = {$urandom(), $urandom(), $urandom(), $urandom()};
        fragmentProcessed   = r;
        fragmentProcessedCe = r ? 1'b1 : 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        #2;
        check_val("rst_m_tvalid", m_frag_tvalid, 0);
        check_val("rst_m_tkeep", m_frag_tkeep, 0);
        check_val("rst_m_tlast", m_frag_tlast, 0);
        check_val("rst_m_tindex", m_frag_tindex, 0);
        check_val("rst_m_tpayload", m_frag_tpayload, 0);
        check_val("rst_inFlight", inFlight, 0);
        check_val("rst_retireError", retireError, 0);
        check_val("rst_flushDone", flushDone, 0);
        model_reset();
        @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && (exp_q.size() > 0 || mv); g++) drive(0, 0, '0, exp_q.size() > 0);
    endtask

    initial begin
        areset = 1'b1; s_frag_tvalid = 0; s_frag_tkeep = 0; s_frag_tlast = 0;
        s_frag_tindex = '0; s_frag_tpayload = '0; m_frag_tready = 1;
        fragmentProcessed = 0; fragmentProcessedCe = 0; flush = 0;
        #3;
        do_reset();

        // Four distinct indices, each retired four cycles after issue.
        peak = 0;
        for (int c = 0; c < 8; c++) drive(c < 4, 1, IW'(c), c >= 4);
        check_val("stream_peak", peak, 4);
        check_val("stream_empty", inFlight, 0);

        // Back-to-back same index: the second waits until after the retire cycle.
        drive(1, 1, 5, 0);
        drive(1, 1, 5, 0);
        check_val("hazard_held", inFlight, 1);
        drive(1, 1, 5, 1);
        check_val("hazard_after_retire", inFlight, 0);
        drive(1, 1, 5, 0);
        check_val("hazard_accepted", inFlight, 1);
        drain();

        // A bubble with the same index is never a hazard.
        drive(1, 0, 7, 0);
        drive(1, 1, 7, 0);
        check_val("bubble_no_stall", inFlight, 2);
        drain();

        // Fill the scoreboard; the ninth waits, even across the retire cycle.
        for (int i = 0; i < 9; i++) drive(1, 1, IW'(100 + i), 0);
        check_val("full_count", inFlight, 8);
        drive(1, 1, 108, 1);
        check_val("full_retire_no_accept", inFlight, 7);
        drive(1, 1, 108, 0);
        check_val("full_then_accept", inFlight, 8);
        drain();

        // Flush with three in flight.
        for (int i = 0; i < 3; i++) drive(1, 1, IW'(20 + i), 0);
        flush = 1; pulses = 0;
        for (int c = 0; c < 12; c++) drive(1, 1, IW'(30), (c % 2 == 1) && exp_q.size() > 0);
        check_val("flush_pulses", pulses, 1);
        flush = 0;
        drive(0, 0, '0, 0);
        drive(1, 1, 30, 0);
        check_val("flush_released", inFlight, 1);
        drain();

        // Random traffic with a small index range to provoke hazards.
        for (int c = 0; c < 400; c++) begin
            m_frag_tready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) flush = ~flush;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, IW'($urandom_range(0, 7)),
                  exp_q.size() > 0 && $urandom_range(0, 2) == 0);
        end
        flush = 0; m_frag_tready = 1;
        for (int c = 0; c < 4; c++) drive(0, 0, '0, 0);
        drain();

        // Retire with nothing in flight sets the sticky error.
        drive(0, 0, '0, 1);
        check_val("retire_error_set", retireError, 1);
        for (int c = 0; c < 3; c++) drive(1, 1, IW'(c), 0);
        check_val("retire_error_sticky", retireError, 1);
        do_reset();
        drive(1, 1, 9, 0);
        drive(0, 0, '0, 1);
        check_val("post_reset_clean", retireError, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
